sprite_engine: RTL and testbench
================================

Name: sprite_engine

Overview:
- Parametrised multi-sprite generator: NUM_SPRITES independent 8-pixel-wide, SPRITE_H-row sprites, evaluated in parallel against the beam position every clock.
- Emits one pixel per clock with colour index, winning sprite id and per-sprite collision flags.
- CPU accesses each sprite's bitmap, position and attributes over the existing cs/rw/addr/di/dout bus.
- Sits between the video timing generator and the colour mixer.

Parameters:
- NUM_SPRITES, 4, number of sprite slots (1..16).
- SPRITE_H, 8, bitmap rows per sprite (1..12).
- COLOR_W, 4, colour index width (≤4).
- ID_W, 2, sprite id width; must equal clog2(NUM_SPRITES), min 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  register select.
- rw  in  1  1 = write, 0 = read.
- addr  in  ID_W+4  {sprite index, register offset}.
- di  in  8  write data.
- dout  out  8  read data.
- hpos  in  8  beam column.
- vpos  in  7  beam row.
- vsync  in  1  vertical sync.
- pixel  out  1  an opaque sprite pixel is present.
- color  out  COLOR_W  colour of winning sprite.
- sprite_id  out  ID_W  index of winning sprite.

Behaviour:
- Register map per sprite, offset addr[3:0]:
  - 0..SPRITE_H-1: bitmap row r; bit c is column c, bit 0 leftmost.
  - 12: X. 13: Y.
  - 14: ATTR. bit0 enable, bit1 hflip, bit2 vflip, bits[7:4] colour (low COLOR_W bits used).
  - 15: COLL, read-only collision flag in bit0.
  - Other offsets and sprite indices ≥ NUM_SPRITES: writes ignored, reads return 0.
- Bus:
  - Write takes effect at the clk edge where cs=1 and rw=1.
  - Read: dout is registered, valid one cycle after cs=1, rw=0; dout holds when cs=0.
  - A write to offset 15 (any data) clears that sprite's COLL.
- Reset (reset=0, asynchronous):
  - pixel, color, sprite_id, dout, all COLL and all ATTR clear to 0, so every sprite is disabled.
  - Bitmap, X and Y are not reset.
  - Pipeline contents flush to 0; the first valid output appears 3 cycles after reset release.
- Pipeline: fixed latency of 3 clocks from hpos/vpos to pixel/color/sprite_id.
  - S1: per sprite, dx = (hpos − X) mod 256 and dy = ({1'b0,vpos} − Y) mod 256, both 8-bit.
  - S2: in_range = enable & dx<8 & dy<SPRITE_H.
    - row = vflip ? SPRITE_H−1−dy : dy.
    - col = hflip ? 7−dx[2:0] : dx[2:0].
    - hit = in_range & bitmap[row][col].
  - S3: lowest-index hit sprite wins.
    - pixel=1, color = its ATTR colour, sprite_id = its index.
    - No hit: pixel=0, color=0, sprite_id=0.
- Wrap-around: modular arithmetic is intended. X=252 draws columns 252..255 then 0..3; likewise for Y.
- Collision:
  - When ≥2 sprites hit in the same S2 cycle, COLL of every hitting sprite is set (sticky).
  - All COLL clear on the rising edge of vsync, detected from a registered copy of vsync.
  - If set and clear occur in the same cycle (vsync edge or offset-15 write), set wins.
- Live update: no shadow registers. A write lands on the next clock edge, so a pixel already in flight may use old or new values. Software updates during vsync.
- Disabled sprites never hit and never collide.

Decomposition:
- Package sprite_pkg holds:
  - register offsets: ROW_BASE=0, REG_X=12, REG_Y=13, REG_ATTR=14, REG_COLL=15;
  - ATTR bit positions: ENABLE=0, HFLIP=1, VFLIP=2, COLOR_LSB=4;
  - pipeline latency constant = 3.
- Sub-module sprite_slot, instantiated NUM_SPRITES times:
  - owns one sprite's registers, S1/S2 datapath and COLL flop;
  - outputs hit, colour and read data.
- Top level holds address decode, read mux, collision detect and the S3 priority encoder.

Test Plan:
- Reset → all outputs 0; with all sprites disabled, a full frame sweep gives pixel=0 every cycle.
- Sprite0: X=10, Y=5, row0=0x01, ATTR=0x31; hpos=10, vpos=5 → pixel=1, color=3, sprite_id=0 exactly 3 clocks later; hpos=11 gives pixel=0.
- Same sprite with hflip (ATTR=0x33) → hit moves to hpos=17; with vflip and row7=0x01 → hit at vpos=5.
- Sprite0 and sprite2 overlapping at (40,20), colours 5 and 9 → color=5, sprite_id=0, both COLL read 1. After a vsync rising edge both read 0; a write to sprite2 offset 15 also clears it.
- X=254, row0=0xFF, enabled → pixel=1 at hpos 254, 255, 0..5; pixel=0 at 6 and 253.
- Read-back: write 0xA5 to sprite1 offset 3, read → dout=0xA5 one cycle later. Read of offset 9 with SPRITE_H=8 → 0x00. Assert reset mid-frame → outputs 0 immediately, ATTR=0.

Source files
------------

// File: rtl/sprite_engine_pkg.sv
// Shared constants for the sprite engine: register map, ATTR bit layout,
// pipeline depth and a register-offset decoder.
package sprite_pkg;

  localparam logic [3:0] ROW_BASE = 4'd0;
  localparam logic [3:0] REG_X    = 4'd12;
  localparam logic [3:0] REG_Y    = 4'd13;
  localparam logic [3:0] REG_ATTR = 4'd14;
  localparam logic [3:0] REG_COLL = 4'd15;

  localparam int unsigned ENABLE    = 0;
  localparam int unsigned HFLIP     = 1;
  localparam int unsigned VFLIP     = 2;
  localparam int unsigned COLOR_LSB = 4;

  localparam int unsigned PIPE_LATENCY = 3;

  typedef enum logic [2:0] {
    KIND_ROW,
    KIND_X,
    KIND_Y,
    KIND_ATTR,
    KIND_COLL,
    KIND_NONE
  } reg_kind_e;

  // Classify a per-sprite register offset; rows beyond the bitmap height are holes.
  function automatic reg_kind_e decode_off(input logic [3:0] off, input logic [3:0] rows);
    case (off)
      REG_X:    return KIND_X;
      REG_Y:    return KIND_Y;
      REG_ATTR: return KIND_ATTR;
      REG_COLL: return KIND_COLL;
      default:  return ((off - ROW_BASE) < rows) ? KIND_ROW : KIND_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sprite_engine_if.sv
// CPU register bus of the sprite engine.
interface sprite_engine_if #(
  parameter int ID_W = 2
);
  logic            cs;
  logic            rw;
  logic [ID_W+3:0] addr;
  logic [7:0]      di;
  logic [7:0]      dout;

  modport master (output cs, rw, addr, di, input dout);
  modport slave  (input cs, rw, addr, di, output dout);
endinterface

// File: rtl/sprite_engine_slot.sv
// One sprite slot: its registers, the S1 offset stage, the S2 hit stage
// and its sticky collision flag.
module sprite_slot
  import sprite_pkg::*;
#(
  parameter int SPRITE_H = 8,
  parameter int COLOR_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we_i,
  input  logic [3:0]         off_i,
  input  logic [7:0]         di_i,
  output logic [7:0]         rdata_o,
  input  logic [7:0]         hpos_i,
  input  logic [6:0]         vpos_i,
  input  logic               coll_set_i,
  input  logic               coll_clr_i,
  output logic               hit_o,
  output logic [COLOR_W-1:0] color_o
);

  localparam logic [7:0] H8 = 8'(SPRITE_H);

  logic [7:0] bitmap_q [SPRITE_H];
  logic [7:0] x_q, y_q, attr_q;
  logic       coll_q;
  logic [7:0] dx_d, dy_d, dx_q, dy_q;
  logic       hit_d, hit_q;
  logic       in_range;
  logic [7:0] row_idx, row_bits;
  logic [2:0] col_idx;
  logic [3:0] row_off;
  reg_kind_e  kind;

  assign kind    = decode_off(off_i, 4'(SPRITE_H));
  assign row_off = off_i - ROW_BASE;

  // Bitmap and position registers are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      if (kind == KIND_X) x_q <= di_i;
      if (kind == KIND_Y) y_q <= di_i;
      if (kind == KIND_ROW) begin
        for (int unsigned r = 0; r < SPRITE_H; r++) begin
          if (row_off == 4'(r)) bitmap_q[r] <= di_i;
        end
      end
    end
  end

  // ATTR resets to zero so every sprite starts disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) attr_q <= '0;
    else if (we_i && kind == KIND_ATTR) attr_q <= di_i;
  end

  // Sticky collision flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) coll_q <= 1'b0;
    else if (coll_set_i) coll_q <= 1'b1;
    else if (coll_clr_i || (we_i && kind == KIND_COLL)) coll_q <= 1'b0;
  end

  // Register read-back for the CPU read mux.
  always_comb begin
    rdata_o = '0;
    case (kind)
      KIND_ROW: begin
        for (int unsigned r = 0; r < SPRITE_H; r++) begin
          if (row_off == 4'(r)) rdata_o = bitmap_q[r];
        end
      end
      KIND_X:    rdata_o = x_q;
      KIND_Y:    rdata_o = y_q;
      KIND_ATTR: rdata_o = attr_q;
      KIND_COLL: rdata_o = {7'd0, coll_q};
      default:   rdata_o = '0;
    endcase
  end

  // S1: beam offset relative to the sprite origin, modulo 256.
  always_comb begin
    dx_d = hpos_i - x_q;
    dy_d = {1'b0, vpos_i} - y_q;
  end

  // S1 register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  // S2: range test, flips and bitmap lookup.
  always_comb begin
    in_range = attr_q[ENABLE] && (dx_q < 8'd8) && (dy_q < H8);
    row_idx  = attr_q[VFLIP] ? (H8 - 8'd1 - dy_q) : dy_q;
    col_idx  = attr_q[HFLIP] ? (3'd7 - dx_q[2:0]) : dx_q[2:0];
    row_bits = '0;
    for (int unsigned r = 0; r < SPRITE_H; r++) begin
      if (row_idx == 8'(r)) row_bits = bitmap_q[r];
    end
    hit_d = in_range && row_bits[col_idx];
  end

  // S2 register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hit_q <= 1'b0;
    else hit_q <= hit_d;
  end

  assign hit_o   = hit_q;
  assign color_o = attr_q[COLOR_LSB +: COLOR_W];

endmodule

// File: rtl/sprite_engine.sv
// Multi-sprite generator: address decode, read mux, collision detect and
// the final lowest-index-wins priority stage over NUM_SPRITES slots.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_H    = 8,
  parameter int COLOR_W     = 4,
  parameter int ID_W        = 2
) (
  input  logic               clk,
  input  logic               reset,
  sprite_engine_if.slave     bus,
  input  logic [7:0]         hpos,
  input  logic [6:0]         vpos,
  input  logic               vsync,
  output logic               pixel,
  output logic [COLOR_W-1:0] color,
  output logic [ID_W-1:0]    sprite_id
);

  logic [3:0]             off;
  logic [ID_W-1:0]        idx;
  logic [NUM_SPRITES-1:0] we_vec, hit_vec, coll_set;
  logic [7:0]             slot_rdata [NUM_SPRITES];
  logic [COLOR_W-1:0]     slot_color [NUM_SPRITES];
  logic [7:0]             rdata_sel, dout_q;
  logic                   vsync_q, vsync_rise, multi_hit;
  logic                   pixel_d, pixel_q, found;
  logic [COLOR_W-1:0]     color_d, color_q;
  logic [ID_W-1:0]        id_d, id_q;

  assign off = bus.addr[3:0];
  assign idx = bus.addr[ID_W+3:4];

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
    sprite_slot #(
      .SPRITE_H (SPRITE_H),
      .COLOR_W  (COLOR_W)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .we_i       (we_vec[i]),
      .off_i      (off),
      .di_i       (bus.di),
      .rdata_o    (slot_rdata[i]),
      .hpos_i     (hpos),
      .vpos_i     (vpos),
      .coll_set_i (coll_set[i]),
      .coll_clr_i (vsync_rise),
      .hit_o      (hit_vec[i]),
      .color_o    (slot_color[i])
    );
  end

  // Sprite-index decode; indices with no slot select nothing and read as 0.
  always_comb begin
    we_vec    = '0;
    rdata_sel = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (idx == ID_W'(i)) begin
        we_vec[i] = bus.cs && bus.rw;
        rdata_sel = slot_rdata[i];
      end
    end
  end

  // Registered read data, held while no read is in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dout_q <= '0;
    else if (bus.cs && !bus.rw) dout_q <= rdata_sel;
  end

  assign bus.dout = dout_q;

  // Delayed vsync for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vsync_q <= 1'b0;
    else vsync_q <= vsync;
  end

  assign vsync_rise = vsync && !vsync_q;

  // Two or more hits at once flag every hitting sprite.
  always_comb begin
    multi_hit = |(hit_vec & (hit_vec - NUM_SPRITES'(1)));
    coll_set  = multi_hit ? hit_vec : '0;
  end

  // S3: lowest-index hitting sprite wins.
  always_comb begin
    found   = 1'b0;
    color_d = '0;
    id_d    = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (hit_vec[i] && !found) begin
        found   = 1'b1;
        color_d = slot_color[i];
        id_d    = ID_W'(i);
      end
    end
    pixel_d = found;
  end

  // S3 output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_q <= 1'b0;
      color_q <= '0;
      id_q    <= '0;
    end else begin
      pixel_q <= pixel_d;
      color_q <= color_d;
      id_q    <= id_d;
    end
  end

  assign pixel     = pixel_q;
  assign color     = color_q;
  assign sprite_id = id_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: beam expectations go into a
// scoreboard queue and are compared when they emerge from the pipeline;
// bus read-backs are compared inline in each scenario task.
module tb_sprite_engine;
  import sprite_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hpos;
  logic [6:0] vpos;
  logic       vsync;
  logic       pixel;
  logic [3:0] color;
  logic [1:0] sprite_id;

  sprite_engine_if #(.ID_W(2)) bus ();

  sprite_engine #(
    .NUM_SPRITES (4),
    .SPRITE_H    (8),
    .COLOR_W     (4),
    .ID_W        (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .hpos      (hpos),
    .vpos      (vpos),
    .vsync     (vsync),
    .pixel     (pixel),
    .color     (color),
    .sprite_id (sprite_id)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    bit          chk;
    bit          p;
    logic [3:0]  c;
    logic [1:0]  id;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Scoreboard: compare each expected pixel when it reaches the output.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.chk) begin
        checks++;
        if (e.due != cyc || pixel !== e.p || color !== e.c || sprite_id !== e.id) begin
          failures++;
          $display("FAIL beam hpos/vpos entry: got pixel=%0b color=%0d id=%0d, expected pixel=%0b color=%0d id=%0d (cyc %0d)",
                   pixel, color, sprite_id, e.p, e.c, e.id, cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic beam(input logic [7:0] h, input logic [6:0] v, input bit chk,
                      input bit p, input logic [3:0] c, input logic [1:0] id);
    exp_t e;
    hpos  = h;
    vpos  = v;
    e.due = cyc + PIPE_LATENCY;
    e.chk = chk;
    e.p   = p;
    e.c   = c;
    e.id  = id;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) beam(8'd200, 7'd100, 1'b0, 1'b0, 4'd0, 2'd0);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [3:0] off, input logic [7:0] d);
    bus.cs   = 1'b1;
    bus.rw   = 1'b1;
    bus.addr = {idx, off};
    bus.di   = d;
    @(negedge clk);
    bus.cs = 1'b0;
    bus.rw = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx, input logic [3:0] off, output logic [7:0] d);
    bus.cs   = 1'b1;
    bus.rw   = 1'b0;
    bus.addr = {idx, off};
    @(negedge clk);
    bus.cs = 1'b0;
    d = bus.dout;
  endtask

  task automatic load(input logic [1:0] idx, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] attr, input logic [63:0] rows);
    wr(idx, REG_X, x);
    wr(idx, REG_Y, y);
    for (int unsigned r = 0; r < 8; r++) wr(idx, 4'(r), rows[8*r +: 8]);
    wr(idx, REG_ATTR, attr);
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset    = 1'b1;
    bus.cs   = 1'b0;
    bus.rw   = 1'b0;
    bus.addr = '0;
    bus.di   = '0;
    hpos     = 8'd200;
    vpos     = 7'd100;
    vsync    = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pixel !== 1'b0 || color !== 4'd0 || sprite_id !== 2'd0 || bus.dout !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: got pixel=%0b color=%0d id=%0d dout=%0h, expected all 0",
               pixel, color, sprite_id, bus.dout);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      rd(2'(i), REG_ATTR, d);
      checks++;
      if (d !== 8'h00) begin
        failures++;
        $display("FAIL reset_attr[%0d]: got %0h, expected 00", i, d);
      end
      rd(2'(i), REG_COLL, d);
      checks++;
      if (d !== 8'h00) begin
        failures++;
        $display("FAIL reset_coll[%0d]: got %0h, expected 00", i, d);
      end
    end
  endtask

  task automatic test_disabled_sweep();
    for (int unsigned v = 0; v < 128; v++)
      for (int unsigned h = 0; h < 256; h++)
        beam(8'(h), 7'(v), 1'b1, 1'b0, 4'd0, 2'd0);
    idle(3);
  endtask

  task automatic test_basic();
    load(2'd0, 8'd10, 8'd5, 8'h31, 64'h01);
    beam(8'd10, 7'd5, 1'b1, 1'b1, 4'd3, 2'd0);
    beam(8'd11, 7'd5, 1'b1, 1'b0, 4'd0, 2'd0);
    beam(8'd9,  7'd5, 1'b1, 1'b0, 4'd0, 2'd0);
    beam(8'd10, 7'd6, 1'b1, 1'b0, 4'd0, 2'd0);
    beam(8'd10, 7'd5, 1'b1, 1'b1, 4'd3, 2'd0);
    idle(3);
  endtask

  task automatic test_flip();
    wr(2'd0, REG_ATTR, 8'h33);
    beam(8'd17, 7'd5, 1'b1, 1'b1, 4'd3, 2'd0);
    beam(8'd10, 7'd5, 1'b1, 1'b0, 4'd0, 2'd0);
    beam(8'd16, 7'd5, 1'b1, 1'b0, 4'd0, 2'd0);
    idle(3);
    wr(2'd0, 4'd0, 8'h00);
    wr(2'd0, 4'd7, 8'h01);
    wr(2'd0, REG_ATTR, 8'h35);
    beam(8'd10, 7'd5,  1'b1, 1'b1, 4'd3, 2'd0);
    beam(8'd10, 7'd12, 1'b1, 1'b0, 4'd0, 2'd0);
    beam(8'd17, 7'd5,  1'b1, 1'b0, 4'd0, 2'd0);
    idle(3);
  endtask

  task automatic test_collision();
    logic [7:0] d;
    load(2'd0, 8'd40, 8'd20, 8'h51, 64'h01);
    load(2'd2, 8'd40, 8'd20, 8'h91, 64'h01);
    beam(8'd40, 7'd20, 1'b1, 1'b1, 4'd5, 2'd0);
    beam(8'd41, 7'd20, 1'b1, 1'b0, 4'd0, 2'd0);
    idle(3);
    rd(2'd0, REG_COLL, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL coll_s0_set: got %0h, expected 01", d); end
    rd(2'd2, REG_COLL, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL coll_s2_set: got %0h, expected 01", d); end
    rd(2'd1, REG_COLL, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL coll_s1_clear: got %0h, expected 00", d); end
    pulse_vsync();
    rd(2'd0, REG_COLL, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL coll_s0_vsync: got %0h, expected 00", d); end
    rd(2'd2, REG_COLL, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL coll_s2_vsync: got %0h, expected 00", d); end
    // Sprite 0 disabled: sprite 2 alone wins and does not collide.
    wr(2'd0, REG_ATTR, 8'h50);
    beam(8'd40, 7'd20, 1'b1, 1'b1, 4'd9, 2'd2);
    idle(3);
    rd(2'd2, REG_COLL, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL coll_single_hit: got %0h, expected 00", d); end
    wr(2'd0, REG_ATTR, 8'h51);
    beam(8'd40, 7'd20, 1'b1, 1'b1, 4'd5, 2'd0);
    idle(3);
    rd(2'd2, REG_COLL, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL coll_s2_reset: got %0h, expected 01", d); end
    wr(2'd2, REG_COLL, 8'h00);
    rd(2'd2, REG_COLL, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL coll_s2_wrclear: got %0h, expected 00", d); end
    rd(2'd0, REG_COLL, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL coll_s0_kept: got %0h, expected 01", d); end
    pulse_vsync();
    wr(2'd2, REG_ATTR, 8'h00);
  endtask

  task automatic test_wrap();
    load(2'd0, 8'd254, 8'd20, 8'h71, 64'hFF);
    beam(8'd253, 7'd20, 1'b1, 1'b0, 4'd0, 2'd0);
    beam(8'd254, 7'd20, 1'b1, 1'b1, 4'd7, 2'd0);
    beam(8'd255, 7'd20, 1'b1, 1'b1, 4'd7, 2'd0);
    for (int unsigned h = 0; h < 6; h++) beam(8'(h), 7'd20, 1'b1, 1'b1, 4'd7, 2'd0);
    beam(8'd6, 7'd20, 1'b1, 1'b0, 4'd0, 2'd0);
    idle(3);
    wr(2'd0, REG_X, 8'd100);
    wr(2'd0, REG_Y, 8'd250);
    wr(2'd0, 4'd6, 8'h01);
    beam(8'd100, 7'd0,   1'b1, 1'b1, 4'd7, 2'd0);
    beam(8'd100, 7'd1,   1'b1, 1'b0, 4'd0, 2'd0);
    beam(8'd100, 7'd127, 1'b1, 1'b0, 4'd0, 2'd0);
    idle(3);
  endtask

  task automatic test_readback();
    logic [7:0] d;
    wr(2'd1, 4'd3, 8'hA5);
    rd(2'd1, 4'd3, d);
    checks++;
    if (d !== 8'hA5) begin failures++; $display("FAIL rb_row3: got %0h, expected a5", d); end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.dout !== 8'hA5) begin failures++; $display("FAIL rb_hold: got %0h, expected a5", bus.dout); end
    rd(2'd1, 4'd9, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL rb_hole: got %0h, expected 00", d); end
    wr(2'd1, 4'd9, 8'hFF);
    rd(2'd1, 4'd9, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL rb_hole_wr: got %0h, expected 00", d); end
    wr(2'd1, REG_X, 8'h3C);
    rd(2'd1, REG_X, d);
    checks++;
    if (d !== 8'h3C) begin failures++; $display("FAIL rb_x: got %0h, expected 3c", d); end
    rd(2'd1, 4'd3, d);
    checks++;
    if (d !== 8'hA5) begin failures++; $display("FAIL rb_row3_again: got %0h, expected a5", d); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    wr(2'd0, REG_X, 8'd60);
    wr(2'd0, REG_Y, 8'd30);
    rd(2'd0, REG_X, d);
    checks++;
    if (d !== 8'd60) begin failures++; $display("FAIL mid_x_before: got %0d, expected 60", d); end
    repeat (4) beam(8'd60, 7'd30, 1'b1, 1'b1, 4'd7, 2'd0);
    checks++;
    if (pixel !== 1'b1) begin failures++; $display("FAIL mid_active: got pixel=%0b, expected 1", pixel); end
    sb.delete();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pixel !== 1'b0 || color !== 4'd0 || sprite_id !== 2'd0 || bus.dout !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got pixel=%0b color=%0d id=%0d dout=%0h, expected all 0",
               pixel, color, sprite_id, bus.dout);
    end
    @(negedge clk);
    reset = 1'b1;
    rd(2'd0, REG_ATTR, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL mid_attr: got %0h, expected 00", d); end
    rd(2'd0, REG_X, d);
    checks++;
    if (d !== 8'd60) begin failures++; $display("FAIL mid_x_kept: got %0d, expected 60", d); end
    beam(8'd60, 7'd30, 1'b1, 1'b0, 4'd0, 2'd0);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_disabled_sweep();
    test_basic();
    test_flip();
    test_collision();
    test_wrap();
    test_readback();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
